flit_receiver: RTL and testbench
================================

Name: flit_receiver

Overview:
- Receive-side endpoint of the processor/router link: accepts 9-bit flits from the router ({last, 8-bit sequence payload}) and buffers them in a small FIFO for the local processor.
- Checks that payloads follow the transmitter's counting sequence (1, 2, 3 ..., wrapping 255 -> 1).
- Reports packet completion with flit count, sequence errors, and packet aborts on inter-flit timeout.
- Sits between the router's local output port and the processor core, mirroring the transmit path.

Parameters:
- DEPTH, 8, FIFO depth in flits; power of two, minimum 2.
- TIMEOUT, 16, idle cycles allowed between flits inside a packet before abort; minimum 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flit_valid  input  1  router presents a flit on flit_data.
- flit_data  input  9  [8] last-flit flag, [7:0] sequence payload.
- flit_ready  output  1  receiver can accept a flit this cycle.
- rd_en  input  1  processor pops the FIFO head.
- rd_data  output  9  FIFO head {last, payload}; valid when rd_empty=0.
- rd_empty  output  1  FIFO empty.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- pkt_done  output  1  one-cycle pulse: last flit of a packet accepted.
- pkt_len  output  8  flits in the completed packet; valid with pkt_done, held until the next pkt_done.
- seq_err  output  1  sticky: sequence mismatch in the current or last packet.
- pkt_abort  output  1  one-cycle pulse: packet abandoned on timeout.

Behaviour:
- Reset (async) values:
  - state=IDLE; FIFO empty; rd_empty=1; fifo_level=0.
  - flit_ready=1; pkt_done=0; pkt_len=0; seq_err=0; pkt_abort=0.
  - Internal: expected=1; len_cnt=0; idle_cnt=0.
- Accept: a flit is accepted when flit_valid & flit_ready at a rising clock edge.
- flit_ready = ~full, combinational from registered occupancy.
- FIFO:
  - Write on accept; read when rd_en & ~rd_empty.
  - rd_data shows the head combinationally; rd_en while empty is ignored.
  - Simultaneous read and write leaves the level unchanged.
  - When full, flit_ready=0 even if rd_en is high that cycle; no write bypass.
- State machine:
  - IDLE:
    - On accept of a non-last flit: compare payload with 1, set len_cnt=1, go to RECV.
    - On accept of a last flit (single-flit packet): compare, pulse pkt_done with pkt_len=1, stay in IDLE.
    - seq_err clears at every packet start (first accepted flit), then is set by that flit's own mismatch.
  - RECV:
    - On each accept: compare payload with expected; len_cnt+1, saturating at 255; idle_cnt=0.
    - On a last flit: pulse pkt_done the cycle after the accept edge, pkt_len=len_cnt including this flit, go to IDLE, expected=1.
    - Cycles without an accept increment idle_cnt, including cycles where flit_valid is high but flit_ready is low.
    - When idle_cnt reaches TIMEOUT: pulse pkt_abort, go to IDLE, expected=1, len_cnt=0. Flits already buffered are kept.
- Sequence check:
  - Mismatch sets seq_err.
  - After every accept, expected = received payload + 1, with 255 -> 1. This resynchronises after an error and models the transmitter wrap.
  - A payload of 0 is always a mismatch.
- Output pulses are registered, one cycle wide, asserted the cycle after the causing edge. pkt_done and pkt_abort are never asserted in the same cycle.
- Reset mid-packet discards all buffered flits and returns to IDLE immediately.

Test Plan:
- Packet payloads 1,2,3,4, with bit 8 set on payload 4, one flit per cycle, no reads -> pkt_done pulses once, pkt_len=4, seq_err=0, fifo_level=4, rd_data=9'h001.
- Single flit 9'h101 from IDLE -> pkt_done with pkt_len=1; next packet 1,2(last) -> pkt_len=2, seq_err=0.
- Payloads 1,2,5,6(last) -> seq_err=1 after the third flit, no further error on 6 (expected resynced to 6); pkt_len=4; next packet starting at 1 clears seq_err.
- DEPTH=8, rd_en=0, stream 10 non-last flits -> flit_ready drops after the 8th accept; simultaneous rd_en with a valid flit while full -> no write that cycle, level 7 next cycle, then accept resumes.
- TIMEOUT=16, send 1,2 then flit_valid=0 for 16 cycles -> pkt_abort pulses once, state IDLE, the 2 flits remain readable; next flit 1 starts a fresh packet.
- Payload run 254,255,1(last), started from IDLE at 1 and counting through 255 -> no seq_err at the wrap, pkt_len saturates at 255.

Source files
------------

// File: rtl/flit_receiver.sv
// flit_receiver: receive-side endpoint of the processor/router link.
// Buffers incoming {last, payload} flits in a small FIFO for the local core,
// checks the payload counting sequence (1..255, wrapping to 1), and reports
// packet completion, sequence errors and inter-flit timeouts.
module flit_receiver #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_flit_valid,
    input  logic [8:0]               i_flit_data,
    output logic                     o_flit_ready,
    input  logic                     i_rd_en,
    output logic [8:0]               o_rd_data,
    output logic                     o_rd_empty,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic                     o_pkt_done,
    output logic [7:0]               o_pkt_len,
    output logic                     o_seq_err,
    output logic                     o_pkt_abort
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(TIMEOUT + 1);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    // Next value of the expected payload: the transmitter counts 1..255 and
    // wraps back to 1, never emitting 0.
    function automatic logic [7:0] seq_next(input logic [7:0] p);
        return (p == 8'hFF) ? 8'h01 : p + 8'h01;
    endfunction

    // Packet length counter, saturating at 255.
    function automatic logic [7:0] len_inc(input logic [7:0] n);
        return (n == 8'hFF) ? 8'hFF : n + 8'h01;
    endfunction

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_full  = (r_level == FULL_LEVEL);
    assign w_empty = (r_level == LW'(0));
    // No write bypass: a pop in the same cycle does not open a slot.
    assign w_wr    = i_flit_valid & ~w_full;
    assign w_rd    = i_rd_en & ~w_empty;

    assign o_flit_ready = ~w_full;
    assign o_rd_data    = r_mem[r_rd_ptr];
    assign o_rd_empty   = w_empty;
    assign o_fifo_level = r_level;

    // Storage array; contents need no reset since the level gates visibility.
    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_flit_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= AW'(0);
            r_rd_ptr <= AW'(0);
            r_level  <= LW'(0);
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Packet tracking FSM
    // ------------------------------------------------------------------
    state_t        r_state;
    logic [7:0]    r_expected;
    logic [7:0]    r_len_cnt;
    logic [IW-1:0] r_idle_cnt;
    logic [7:0]    r_pkt_len;
    logic          r_seq_err;
    logic          r_pkt_done;
    logic          r_pkt_abort;

    state_t        w_state_nx;
    logic [7:0]    w_expected_nx;
    logic [7:0]    w_len_cnt_nx;
    logic [IW-1:0] w_idle_cnt_nx;
    logic [7:0]    w_pkt_len_nx;
    logic          w_seq_err_nx;
    logic          w_pkt_done_nx;
    logic          w_pkt_abort_nx;

    logic       w_last;
    logic [7:0] w_payload;
    logic [7:0] w_cmp_value;
    logic       w_mismatch;

    assign w_last      = i_flit_data[8];
    assign w_payload   = i_flit_data[7:0];
    // A packet always starts at 1; inside a packet compare with the tracked value.
    assign w_cmp_value = (r_state == ST_IDLE) ? 8'h01 : r_expected;
    assign w_mismatch  = (w_payload != w_cmp_value);

    // Next-state and next-output decode for the packet tracker.
    always_comb begin
        w_state_nx     = r_state;
        w_expected_nx  = r_expected;
        w_len_cnt_nx   = r_len_cnt;
        w_idle_cnt_nx  = r_idle_cnt;
        w_pkt_len_nx   = r_pkt_len;
        w_seq_err_nx   = r_seq_err;
        w_pkt_done_nx  = 1'b0;
        w_pkt_abort_nx = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_wr) begin
                    // New packet: the error flag restarts with this flit.
                    w_seq_err_nx  = w_mismatch;
                    w_idle_cnt_nx = IW'(0);
                    if (w_last) begin
                        w_pkt_done_nx = 1'b1;
                        w_pkt_len_nx  = 8'd1;
                        w_expected_nx = 8'h01;
                        w_len_cnt_nx  = 8'd0;
                        w_state_nx    = ST_IDLE;
                    end else begin
                        w_len_cnt_nx  = 8'd1;
                        w_expected_nx = seq_next(w_payload);
                        w_state_nx    = ST_RECV;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end

            ST_RECV: begin
                if (w_wr) begin
                    w_seq_err_nx  = r_seq_err | w_mismatch;
                    w_idle_cnt_nx = IW'(0);
                    if (w_last) begin
                        w_pkt_done_nx = 1'b1;
                        w_pkt_len_nx  = len_inc(r_len_cnt);
                        w_len_cnt_nx  = 8'd0;
                        w_expected_nx = 8'h01;
                        w_state_nx    = ST_IDLE;
                    end else begin
                        w_len_cnt_nx  = len_inc(r_len_cnt);
                        w_expected_nx = seq_next(w_payload);
                    end
                end else if (r_idle_cnt == IDLE_LAST) begin
                    // Link went quiet mid-packet: abandon it, keep buffered flits.
                    w_pkt_abort_nx = 1'b1;
                    w_idle_cnt_nx  = IW'(0);
                    w_len_cnt_nx   = 8'd0;
                    w_expected_nx  = 8'h01;
                    w_state_nx     = ST_IDLE;
                end else begin
                    w_idle_cnt_nx = r_idle_cnt + IW'(1);
                end
            end

            default: begin
                w_state_nx    = ST_IDLE;
                w_expected_nx = 8'h01;
                w_len_cnt_nx  = 8'd0;
                w_idle_cnt_nx = IW'(0);
            end
        endcase
    end

    // Packet tracker state and registered status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_expected  <= 8'h01;
            r_len_cnt   <= 8'd0;
            r_idle_cnt  <= IW'(0);
            r_pkt_len   <= 8'd0;
            r_seq_err   <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_abort <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_expected  <= w_expected_nx;
            r_len_cnt   <= w_len_cnt_nx;
            r_idle_cnt  <= w_idle_cnt_nx;
            r_pkt_len   <= w_pkt_len_nx;
            r_seq_err   <= w_seq_err_nx;
            r_pkt_done  <= w_pkt_done_nx;
            r_pkt_abort <= w_pkt_abort_nx;
        end
    end

    assign o_pkt_done  = r_pkt_done;
    assign o_pkt_abort = r_pkt_abort;
    assign o_pkt_len   = r_pkt_len;
    assign o_seq_err   = r_seq_err;

endmodule

// File: tb/tb_flit_receiver.sv
// Testbench for flit_receiver: directed scenarios plus randomized traffic,
// all checked against a transaction-level reference model (queue + packet rules).
module tb_flit_receiver;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_flit_valid = 1'b0;
    logic [8:0] i_flit_data  = 9'h000;
    logic       i_rd_en      = 1'b0;
    logic       o_flit_ready;
    logic [8:0] o_rd_data;
    logic       o_rd_empty;
    logic [3:0] o_fifo_level;
    logic       o_pkt_done;
    logic [7:0] o_pkt_len;
    logic       o_seq_err;
    logic       o_pkt_abort;

    flit_receiver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_flit_valid (i_flit_valid),
        .i_flit_data  (i_flit_data),
        .o_flit_ready (o_flit_ready),
        .i_rd_en      (i_rd_en),
        .o_rd_data    (o_rd_data),
        .o_rd_empty   (o_rd_empty),
        .o_fifo_level (o_fifo_level),
        .o_pkt_done   (o_pkt_done),
        .o_pkt_len    (o_pkt_len),
        .o_seq_err    (o_seq_err),
        .o_pkt_abort  (o_pkt_abort)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    logic [8:0] m_q [$];
    bit m_in_pkt  = 1'b0;
    int m_exp     = 1;
    int m_cnt     = 0;
    int m_idle    = 0;
    bit m_seq_err = 1'b0;
    int m_pkt_len = 0;
    bit m_done    = 1'b0;
    bit m_abort   = 1'b0;
    bit m_acc     = 1'b0;
    int n_done_seen  = 0;
    int n_abort_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [8:0] fl(input bit last, input int p);
        logic [7:0] pb;
        pb = 8'(p);
        return {last, pb};
    endfunction

    task automatic check_outputs(input string where);
        check_eq({where, ".pkt_done"},   32'(o_pkt_done),   32'(m_done));
        check_eq({where, ".pkt_abort"},  32'(o_pkt_abort),  32'(m_abort));
        check_eq({where, ".pkt_len"},    32'(o_pkt_len),    32'(m_pkt_len));
        check_eq({where, ".seq_err"},    32'(o_seq_err),    32'(m_seq_err));
        check_eq({where, ".fifo_level"}, 32'(o_fifo_level), 32'(m_q.size()));
        check_eq({where, ".rd_empty"},   32'(o_rd_empty),   32'(m_q.size() == 0));
        check_eq({where, ".flit_ready"}, 32'(o_flit_ready), 32'(m_q.size() < DEPTH));
        if (m_q.size() != 0) begin
            check_eq({where, ".rd_data"}, 32'(o_rd_data), 32'(m_q[0]));
        end
    endtask

    // Drive one clock cycle of stimulus, advance the model, check after the edge.
    task automatic step(input logic v, input logic [8:0] d, input logic rd);
        bit acc;
        bit rdo;
        int p;
        i_flit_valid = v;
        i_flit_data  = d;
        i_rd_en      = rd;
        #1;
        check_eq("ready_pre", 32'(o_flit_ready), 32'(m_q.size() < DEPTH));
        acc = v && (m_q.size() < DEPTH);
        rdo = rd && (m_q.size() > 0);
        if (rdo) m_q.delete(0);
        if (acc) m_q.push_back(d);
        m_done  = 1'b0;
        m_abort = 1'b0;
        p = int'(d[7:0]);
        if (acc) begin
            if (!m_in_pkt) begin
                m_seq_err = (p != 1);
                m_cnt     = 1;
            end else begin
                if (p != m_exp) m_seq_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            m_exp  = (p == 255) ? 1 : p + 1;
            m_idle = 0;
            if (d[8]) begin
                m_done    = 1'b1;
                m_pkt_len = m_cnt;
                m_in_pkt  = 1'b0;
            end else begin
                m_in_pkt = 1'b1;
            end
        end else if (m_in_pkt) begin
            m_idle++;
            if (m_idle == TIMEOUT) begin
                m_abort  = 1'b1;
                m_in_pkt = 1'b0;
            end
        end
        m_acc = acc;
        @(posedge clock);
        #1;
        check_outputs("cyc");
        if (o_pkt_done === 1'b1) n_done_seen++;
        if (o_pkt_abort === 1'b1) n_abort_seen++;
    endtask

    // Asynchronous reset applied between clock edges; checked before any edge.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        m_q.delete();
        m_in_pkt  = 1'b0;
        m_exp     = 1;
        m_cnt     = 0;
        m_idle    = 0;
        m_seq_err = 1'b0;
        m_pkt_len = 0;
        m_done    = 1'b0;
        m_abort   = 1'b0;
        check_outputs("reset");
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        while (m_q.size() != 0) step(1'b0, 9'h000, 1'b1);
    endtask

    initial begin
        int gen;
        int vprob;
        int rprob;
        int p;
        bit last;
        bit v;
        bit rd;
        int d0;
        int a0;

        @(posedge clock);
        #1;
        do_reset();

        // Basic packet 1,2,3,4(last), no reads
        d0 = n_done_seen;
        for (int i = 1; i <= 4; i++) step(1'b1, fl(i == 4, i), 1'b0);
        check_eq("t1.len", 32'(o_pkt_len), 32'd4);
        check_eq("t1.level", 32'(o_fifo_level), 32'd4);
        check_eq("t1.head", 32'(o_rd_data), 32'h001);
        step(1'b0, 9'h000, 1'b0);
        check_eq("t1.done_once", 32'(n_done_seen - d0), 32'd1);
        drain();

        // Single-flit packet then a two-flit packet
        step(1'b1, 9'h101, 1'b0);
        check_eq("t2.len1", 32'(o_pkt_len), 32'd1);
        step(1'b1, fl(1'b0, 1), 1'b0);
        step(1'b1, fl(1'b1, 2), 1'b0);
        check_eq("t2.len2", 32'(o_pkt_len), 32'd2);
        drain();

        // Sequence error with resync: 1,2,5,6(last), then a clean packet
        step(1'b1, fl(1'b0, 1), 1'b1);
        step(1'b1, fl(1'b0, 2), 1'b1);
        step(1'b1, fl(1'b0, 5), 1'b1);
        check_eq("t3.err", 32'(o_seq_err), 32'd1);
        step(1'b1, fl(1'b1, 6), 1'b1);
        check_eq("t3.len", 32'(o_pkt_len), 32'd4);
        step(1'b1, fl(1'b1, 1), 1'b1);
        check_eq("t3.clear", 32'(o_seq_err), 32'd0);
        drain();

        // Fill to full, pop while full with a flit offered, then resume
        for (int i = 1; i <= 10; i++) step(1'b1, fl(1'b0, i), 1'b0);
        check_eq("t4.full_ready", 32'(o_flit_ready), 32'd0);
        step(1'b1, fl(1'b0, 9), 1'b1);
        check_eq("t4.level7", 32'(o_fifo_level), 32'd7);
        step(1'b1, fl(1'b0, 9), 1'b0);
        check_eq("t4.level8", 32'(o_fifo_level), 32'd8);
        a0 = n_abort_seen;
        for (int i = 0; i < TIMEOUT + 2; i++) step(1'b0, 9'h000, 1'b0);
        check_eq("t4.abort_once", 32'(n_abort_seen - a0), 32'd1);
        drain();

        // Timeout after 1,2; buffered flits survive; fresh packet afterwards
        step(1'b1, fl(1'b0, 1), 1'b0);
        step(1'b1, fl(1'b0, 2), 1'b0);
        a0 = n_abort_seen;
        for (int i = 0; i < TIMEOUT; i++) step(1'b0, 9'h000, 1'b0);
        check_eq("t5.abort", 32'(o_pkt_abort), 32'd1);
        check_eq("t5.level", 32'(o_fifo_level), 32'd2);
        step(1'b0, 9'h000, 1'b0);
        check_eq("t5.abort_once", 32'(n_abort_seen - a0), 32'd1);
        step(1'b1, fl(1'b1, 1), 1'b0);
        check_eq("t5.fresh_len", 32'(o_pkt_len), 32'd1);
        drain();

        // Long packet 1..255 then 1(last): wrap is legal, length saturates
        for (int i = 1; i <= 255; i++) step(1'b1, fl(1'b0, i), 1'b1);
        step(1'b1, fl(1'b1, 1), 1'b1);
        check_eq("t6.len_sat", 32'(o_pkt_len), 32'd255);
        check_eq("t6.no_err", 32'(o_seq_err), 32'd0);
        drain();

        // Reset in the middle of a packet
        step(1'b1, fl(1'b0, 1), 1'b0);
        step(1'b1, fl(1'b0, 2), 1'b0);
        step(1'b1, fl(1'b0, 3), 1'b0);
        do_reset();
        step(1'b1, fl(1'b1, 1), 1'b0);
        drain();

        // Randomized traffic with varying link activity and read pressure
        gen   = 1;
        vprob = 90;
        rprob = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                case ($urandom_range(0, 2))
                    0:       vprob = 95;
                    1:       vprob = 50;
                    default: vprob = 3;
                endcase
                rprob = ($urandom_range(0, 1) == 0) ? 25 : 75;
            end
            v    = ($urandom_range(0, 99) < vprob);
            p    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : gen;
            last = ($urandom_range(0, 7) == 0);
            rd   = ($urandom_range(0, 99) < rprob);
            step(v, fl(last, p), rd);
            if (m_acc) gen = last ? 1 : ((p == 255) ? 1 : p + 1);
            if (m_abort) gen = 1;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
